// File: rtl/input_port_buffer.sv
// input_port_buffer: per-input-port flit FIFO with XY routing and output-port request FSM.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_flit    flit from the link or upstream router
//   in_valid   in_flit is valid
//   in_ready   FIFO not full; a flit is pushed when in_valid && in_ready
//   req        one-hot request: [0] local, [1] east, [2] west, [3] north, [4] south
//   gnt        grants from the five output arbiters; only the bit in port_q is used
//   out_flit   FIFO head flit, to the crossbar
//   out_valid  out_flit is transferred (popped) this cycle
//   occupancy  current FIFO fill
//   err_drop   one-cycle pulse when a malformed head-position flit is discarded
//
// Optional feature macro: IBUF_ERR_CHECK_EN. When defined, body/tail flits found at
// the head while idle are discarded with err_drop. Otherwise they are routed as heads.
module input_port_buffer #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4,
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [4:0]               req,
    input  logic [4:0]               gnt,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [X_W-1:0] CX = X_W'(CUR_X);
    localparam logic [Y_W-1:0] CY = Y_W'(CUR_Y);

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    state_t              state_q, state_d;
    logic [4:0]          port_q, port_d;
    logic [FLIT_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;
    logic                push, pop, empty, full, granted, malformed, last;
    logic [1:0]          head_type;
    logic [X_W-1:0]      dx;
    logic [Y_W-1:0]      dy;
    logic [4:0]          route;

    assign full      = count_q == (AW+1)'(DEPTH);
    assign empty     = count_q == '0;
    assign in_ready  = !full;
    // A full FIFO refuses input even when a pop happens in the same cycle.
    assign push      = in_valid && !full;
    assign out_flit  = mem_q[rd_ptr_q];
    assign occupancy = count_q;
    assign head_type = out_flit[FLIT_W-1:FLIT_W-2];
    assign dx        = out_flit[2*X_W-1:X_W];
    assign dy        = out_flit[Y_W-1:0];
    assign granted   = |(gnt & port_q);
    // Tail (10) and single (11) both close the packet.
    assign last      = head_type[1];

    assign route = (dx > CX) ? 5'b00010 :
                   (dx < CX) ? 5'b00100 :
                   (dy > CY) ? 5'b01000 :
                   (dy < CY) ? 5'b10000 : 5'b00001;

`ifdef IBUF_ERR_CHECK_EN
    // Body (00) and tail (10) have type bit 0 clear; they cannot start a packet.
    assign malformed = !head_type[0];
`else
    assign malformed = 1'b0;
`endif

    assign err_drop = (state_q == IDLE) && !empty && malformed;
    assign pop      = out_valid || err_drop;

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        req       = '0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !malformed) begin
                    port_d  = route;
                    state_d = REQ;
                end
            end
            REQ: begin
                req = port_q;
                if (granted) state_d = XFER;
            end
            XFER: begin
                out_valid = granted && !empty;
                // Request drops in the very cycle the closing flit leaves.
                req = (out_valid && last) ? 5'b00000 : port_q;
                if (out_valid && last) state_d = REL;
            end
            REL: begin
                // Wait out the arbiter's trailing grant so it is never reused.
                if (!granted) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            port_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end
endmodule

// File: tb/tb_input_port_buffer.sv
// tb_input_port_buffer: directed self-checking bench for input_port_buffer at CUR=(1,1).
module tb_input_port_buffer;
    logic        clk, rst, in_valid, in_ready, out_valid, err_drop;
    logic [33:0] in_flit, out_flit;
    logic [4:0]  req, gnt;
    logic [2:0]  occupancy;
    int checks = 0;
    int errors = 0;

    input_port_buffer #(
        .FLIT_W(34), .DEPTH(4), .X_W(4), .Y_W(4), .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(in_ready), .req(req), .gnt(gnt), .out_flit(out_flit),
        .out_valid(out_valid), .occupancy(occupancy), .err_drop(err_drop)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Flit layout: type[33:32], zero[31:16], payload[15:8], dx[7:4], dy[3:0].
    function automatic logic [33:0] mk(input logic [1:0] t, input logic [3:0] x,
                                       input logic [3:0] y, input logic [7:0] p);
        return {t, 16'd0, p, x, y};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_flit = '0; gnt = '0;
        #1 rst = 0;
        in_valid = 1; in_flit = mk(2'b11, 4'd1, 4'd1, 8'hAA);
        tick; tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req", req, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_drop", err_drop, 0);

        // Single-flit local packet.
        rst = 1; in_flit = mk(2'b11, 4'd1, 4'd1, 8'hA1);
        tick; in_valid = 0;
        chk("loc_occ1", occupancy, 1);
        chk("loc_req_idle", req, 0);
        tick;
        chk("loc_req", req, 5'b00001);
        chk("loc_ov_req", out_valid, 0);
        tick;
        chk("loc_req_held", req, 5'b00001);
        gnt = 5'b00001;
        chk("loc_ov_in_req", out_valid, 0);
        tick;
        chk("loc_ov", out_valid, 1);
        chk("loc_flit", out_flit, mk(2'b11, 4'd1, 4'd1, 8'hA1));
        chk("loc_req_drop", req, 0);
        tick;
        chk("loc_rel_ov", out_valid, 0);
        chk("loc_rel_occ", occupancy, 0);
        in_valid = 1; in_flit = mk(2'b11, 4'd1, 4'd1, 8'hA2);
        tick; in_valid = 0;
        chk("stale_occ", occupancy, 1);
        chk("stale_ov", out_valid, 0);
        chk("stale_req", req, 0);
        tick;
        chk("stale_req2", req, 0);
        chk("stale_occ2", occupancy, 1);
        gnt = 0;
        tick;
        chk("back_idle_req", req, 0);
        tick;
        chk("loc2_req", req, 5'b00001);
        gnt = 5'b00001;
        tick;
        chk("loc2_ov", out_valid, 1);
        chk("loc2_flit", out_flit, mk(2'b11, 4'd1, 4'd1, 8'hA2));
        tick; gnt = 0; tick;

        // Three-flit packet to the east.
        in_valid = 1; in_flit = mk(2'b01, 4'd2, 4'd1, 8'hB0);
        tick; in_flit = mk(2'b00, 4'd0, 4'd0, 8'hB1);
        tick; in_flit = mk(2'b10, 4'd0, 4'd0, 8'hB2);
        tick; in_valid = 0;
        chk("east_req", req, 5'b00010);
        chk("east_occ", occupancy, 3);
        gnt = 5'b11101;
        tick;
        chk("other_gnt_req", req, 5'b00010);
        chk("other_gnt_ov", out_valid, 0);
        chk("other_gnt_occ", occupancy, 3);
        gnt = 5'b00010;
        tick;
        chk("east_ov0", out_valid, 1);
        chk("east_flit0", out_flit, mk(2'b01, 4'd2, 4'd1, 8'hB0));
        chk("east_req_x", req, 5'b00010);
        tick;
        chk("east_ov1", out_valid, 1);
        chk("east_flit1", out_flit, mk(2'b00, 4'd0, 4'd0, 8'hB1));
        chk("east_occ2", occupancy, 2);
        tick;
        chk("east_ov2", out_valid, 1);
        chk("east_flit2", out_flit, mk(2'b10, 4'd0, 4'd0, 8'hB2));
        chk("east_req_tail", req, 0);
        tick;
        chk("east_rel_occ", occupancy, 0);
        chk("east_rel_ov", out_valid, 0);
        tick;
        chk("east_trail_ov", out_valid, 0);
        chk("east_trail_req", req, 0);
        gnt = 0; tick;

        // FIFO full, then drain westward.
        in_valid = 1; in_flit = mk(2'b01, 4'd0, 4'd1, 8'hC0);
        tick; in_flit = mk(2'b00, 4'd0, 4'd0, 8'hC1);
        tick; in_flit = mk(2'b00, 4'd0, 4'd0, 8'hC2);
        tick; in_flit = mk(2'b00, 4'd0, 4'd0, 8'hC3);
        tick;
        chk("full_in_ready", in_ready, 0);
        chk("full_occ", occupancy, 4);
        in_flit = mk(2'b10, 4'd0, 4'd0, 8'hC4);
        tick;
        chk("full_occ_hold", occupancy, 4);
        chk("west_req", req, 5'b00100);
        gnt = 5'b00100;
        tick;
        chk("full_ov", out_valid, 1);
        chk("full_flit0", out_flit, mk(2'b01, 4'd0, 4'd1, 8'hC0));
        chk("full_occ_x", occupancy, 4);
        tick;
        chk("full_pop_nopush", occupancy, 3);
        chk("full_flit1", out_flit, mk(2'b00, 4'd0, 4'd0, 8'hC1));
        in_valid = 0;
        tick;
        chk("full_flit2", out_flit, mk(2'b00, 4'd0, 4'd0, 8'hC2));
        tick;
        chk("full_flit3", out_flit, mk(2'b00, 4'd0, 4'd0, 8'hC3));
        chk("full_occ1", occupancy, 1);
        tick;
        chk("wait_occ", occupancy, 0);
        chk("wait_ov", out_valid, 0);
        chk("wait_req", req, 5'b00100);
        chk("wait_in_ready", in_ready, 1);
        in_valid = 1;
        tick; in_valid = 0;
        chk("tail_occ", occupancy, 1);
        chk("tail_ov", out_valid, 1);
        chk("tail_flit", out_flit, mk(2'b10, 4'd0, 4'd0, 8'hC4));
        chk("tail_req", req, 0);
        tick;
        chk("tail_done_occ", occupancy, 0);
        gnt = 0; tick;

        // Back-to-back south then north.
        in_valid = 1; in_flit = mk(2'b11, 4'd1, 4'd0, 8'hD0);
        tick; in_flit = mk(2'b11, 4'd1, 4'd3, 8'hD1);
        tick; in_valid = 0;
        chk("south_req", req, 5'b10000);
        chk("south_occ", occupancy, 2);
        gnt = 5'b10000;
        tick;
        chk("south_ov", out_valid, 1);
        chk("south_flit", out_flit, mk(2'b11, 4'd1, 4'd0, 8'hD0));
        chk("south_req_drop", req, 0);
        tick;
        chk("south_rel_req", req, 0);
        chk("south_rel_ov", out_valid, 0);
        chk("south_rel_occ", occupancy, 1);
        tick;
        chk("south_rel_req2", req, 0);
        gnt = 0;
        tick;
        chk("north_idle_req", req, 0);
        tick;
        chk("north_req", req, 5'b01000);
        gnt = 5'b01000;
        tick;
        chk("north_ov", out_valid, 1);
        chk("north_flit", out_flit, mk(2'b11, 4'd1, 4'd3, 8'hD1));
        tick; gnt = 0; tick;

        // Body flit at the head while idle.
        in_valid = 1; in_flit = mk(2'b00, 4'd2, 4'd1, 8'hE0);
        tick; in_flit = mk(2'b11, 4'd1, 4'd1, 8'hE1);
`ifdef IBUF_ERR_CHECK_EN
        chk("mal_err", err_drop, 1);
        chk("mal_occ", occupancy, 1);
        tick; in_valid = 0;
        chk("mal_err_clear", err_drop, 0);
        chk("mal_occ_after", occupancy, 1);
        chk("mal_req", req, 0);
        tick;
        chk("mal_next_req", req, 5'b00001);
        gnt = 5'b00001;
        tick;
        chk("mal_next_ov", out_valid, 1);
        chk("mal_next_flit", out_flit, mk(2'b11, 4'd1, 4'd1, 8'hE1));
        tick; gnt = 0; tick;
`else
        chk("nomal_err", err_drop, 0);
        chk("nomal_occ", occupancy, 1);
        tick; in_valid = 0;
        chk("nomal_occ2", occupancy, 2);
        chk("nomal_req", req, 5'b00010);
        gnt = 5'b00010;
        tick;
        chk("nomal_ov0", out_valid, 1);
        chk("nomal_flit0", out_flit, mk(2'b00, 4'd2, 4'd1, 8'hE0));
        chk("nomal_req_x", req, 5'b00010);
        tick;
        chk("nomal_flit1", out_flit, mk(2'b11, 4'd1, 4'd1, 8'hE1));
        chk("nomal_req_drop", req, 0);
        tick; gnt = 0; tick;
`endif
        chk("end_occ", occupancy, 0);
        chk("end_req", req, 0);
        chk("end_err", err_drop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_port_buffer.md
Name: input_port_buffer

Overview:
- Per-input-port stage of the mesh router that sits directly upstream of the five per-output-port arbiters.
- Buffers incoming flits in a FIFO and performs XY route computation on each head flit.
- Drives one request line to the arbiter of the selected output port and holds it until the packet's tail flit has left.
- Presents the FIFO head flit to the crossbar while its grant is active.

Parameters:
- FLIT_W, 34, flit width; bits [FLIT_W-1:FLIT_W-2] = type (01 head, 00 body, 10 tail, 11 single head+tail).
- DEPTH, 4, FIFO depth in flits; power of two, at least 2.
- X_W, 4, destination X field width; head flit bits [2*X_W-1:X_W].
- Y_W, 4, destination Y field width; head flit bits [Y_W-1:0].
- CUR_X, 0, this router's X coordinate.
- CUR_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- in_flit  in  FLIT_W  flit from the link or upstream router.
- in_valid  in  1  in_flit is valid.
- in_ready  out  1  FIFO can accept a flit (not full).
- req  out  5  one-hot request: [0] local, [1] east, [2] west, [3] north, [4] south.
- gnt  in  5  grants returned by the five output arbiters; bit i belongs to port i.
- out_flit  out  FLIT_W  FIFO head flit, to the crossbar.
- out_valid  out  1  out_flit is transferred this cycle.
- occupancy  out  log2(DEPTH)+1  current FIFO fill.
- err_drop  out  1  one-cycle pulse when a malformed flit is discarded.

Behaviour:
- Reset (rst=0, asynchronous): FIFO pointers and count cleared, FSM in IDLE, port register cleared.
  - Outputs: req=0, out_valid=0, in_ready=1, occupancy=0, err_drop=0.
  - Reset mid-packet discards all buffered flits; no partial output is produced.
- FIFO:
  - Push when in_valid && in_ready; a flit offered while full is not accepted, even if a pop occurs in the same cycle.
  - Pop when out_valid=1.
  - Simultaneous push and pop while neither empty nor full leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - out_flit is the combinational head entry.
- Route (XY), evaluated combinationally on the head flit in IDLE:
  - dx > CUR_X -> east; dx < CUR_X -> west.
  - Otherwise dy > CUR_Y -> north; dy < CUR_Y -> south.
  - Otherwise local.
  - Comparisons are unsigned.
- FSM states:
  - IDLE:
    - FIFO empty -> stay.
    - Head is type head/single -> latch the port one-hot into port_q, go to REQ.
    - Head is a body or tail flit -> malformed (see Optional Feature).
  - REQ:
    - req = port_q.
    - (gnt & port_q) != 0 -> XFER.
    - req is held until granted; the arbiter takes at least 2 cycles because its grant is registered.
  - XFER:
    - req = port_q.
    - out_valid = (gnt & port_q) != 0 && !empty.
    - A popped flit of type tail or single -> req drops in the same cycle, go to REL.
    - Empty FIFO mid-packet -> wait with out_valid=0 and req still held.
  - REL:
    - req = 0, out_valid = 0.
    - Leave for IDLE only once (gnt & port_q) == 0, so a stale grant is never used.
    - The arbiter keeps gnt high 1–2 cycles after req falls; these grants must be ignored.
- Grants on bits other than port_q are ignored in every state.
- out_valid is never 1 outside XFER.

Optional Feature:
- Macro: IBUF_ERR_CHECK_EN.
- Defined:
  - In IDLE, a body or tail flit at the FIFO head is popped and discarded, with err_drop=1 for that cycle.
  - The FSM stays in IDLE.
  - At most one flit is discarded per cycle.
- Undefined:
  - Any flit at the head in IDLE is treated as a head flit and routed from its own bits.
  - err_drop is tied to 0.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> in_ready=1, req=0, occupancy=0, nothing pushed; after release, first push gives occupancy=1 on the next edge.
- Single-flit local packet: CUR=(0,0), in_flit type 11 with dx=0, dy=0 -> req=5'b00001 one cycle later; gnt[0] two cycles later -> out_valid for 1 cycle; req=0; FSM returns to IDLE only after gnt[0] falls.
- 3-flit packet head(dx=2)/body/tail at CUR=(1,1) -> req=5'b00010, three consecutive out_valid pulses in order, req deasserted in the same cycle the tail pops; trailing gnt[1] pulses produce no pops.
- FIFO full: DEPTH=4 with no grant and 5 pushes -> in_ready=0 after the 4th push, 5th flit not stored, occupancy=4; granting then drains all 4 in order and in_ready returns to 1.
- Back-to-back packets to different ports (south, then north, dy=0 then dy=3 at CUR_Y=1): second req=5'b01000 is asserted only after gnt[4] has fallen; no overlap of req bits.
- Malformed head, IBUF_ERR_CHECK_EN defined: body flit first -> err_drop pulses once, occupancy decrements by 1, req stays 0; a following valid head is routed normally.
